id_issue_buffer: RTL and testbench
==================================

# id_issue_buffer

Multi-lane, multi-entry decode-to-issue buffer. It is the parametrised successor of the single-entry ID/issue pipeline register. It accepts up to NrDecodePorts decoded instructions per cycle from parallel decoders and presents up to NrIssuePorts of the oldest entries, in program order, to the issue stage. It sits between the decoder lanes and the scoreboard/issue stage, and supports flush and an optional same-cycle bypass when empty.

## Interface
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration; supplies the widths of issue_entry_t.
- NrDecodePorts, 2: decoder lanes written per cycle (1..4).
- NrIssuePorts, 2: issue lanes read per cycle (1..4).
- Depth, 4: buffer entries; power of two, at least max(NrDecodePorts, NrIssuePorts).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all buffered and incoming entries.
- decoded_entry_i  in  NrDecodePorts x issue_entry_t  decoded instructions; lane 0 is oldest.
- decoded_valid_i  in  NrDecodePorts  per-lane valid.
- decoded_ready_o  out  NrDecodePorts  per-lane ready.
- issue_entry_o  out  NrIssuePorts x issue_entry_t  oldest entries; lane 0 is oldest.
- issue_valid_o  out  NrIssuePorts  per-lane valid.
- issue_ack_i  in  NrIssuePorts  per-lane consume; must be a contiguous prefix of issue_valid_o.
- occupancy_o  out  $clog2(Depth+1)  registered entry count.

## Operation
- Storage is a circular buffer of Depth issue_entry_t. Read pointer rd_q and write pointer wr_q are $clog2(Depth) bits wide and wrap naturally. Count cnt_q runs 0..Depth.
- Pop count P is the number of leading ones in issue_ack_i. Setting issue_ack_i[j] while issue_valid_o[j] is 0 is illegal and covered by an assertion.
- Free slots: F = Depth - cnt_q + P. Same-cycle pops free space, so a full buffer still accepts input while it drains.
- decoded_ready_o[k] = (F > k) and not flush_i and not rst_i.
- Push count A is the number of leading lanes k with decoded_valid_i[k] and decoded_ready_o[k] set. Any lane after the first invalid lane is ignored even if its valid is set, so order is preserved.
- Accepted lane k is written to slot wr_q+k. Next state: wr_q += A, rd_q += P, cnt_q += A - P.
- issue_valid_o[j] = cnt_q > j. issue_entry_o[j] = storage[rd_q+j] when valid, otherwise '0.
- Flush has priority over push and pop. On the next cycle cnt_q = 0 and rd_q = wr_q = 0; entries presented during the flush cycle are dropped.
- Reset is identical to flush, plus every storage entry is cleared to '0.

## Timing
- Reset values: issue_valid_o = 0, issue_entry_o = '0, decoded_ready_o = 0 while rst_i is high and all 1 in the first cycle after reset, occupancy_o = 0.
- Latency without bypass: an entry accepted at edge N is visible on issue_valid_o after edge N, i.e. 1 cycle, matching the legacy register.
- Throughput: min(NrDecodePorts, NrIssuePorts) entries per cycle in steady state with no bubbles.
- Combinational paths: issue_ack_i -> decoded_ready_o and flush_i -> decoded_ready_o. There is no path from decoded_valid_i to any output unless bypass is compiled in.
- Full buffer (cnt_q = Depth) with P = 0: all decoded_ready_o are 0, and entries on decoded_entry_i must be held by the producer.
- Wrap-around: a push of A entries starting at wr_q = Depth-1 writes slots Depth-1, 0, 1, and so on.

## Configuration
- ID_ISSUE_BUF_BYPASS_EN defined:
  - When cnt_q = 0 and flush_i is low, issue lanes j < min(NrDecodePorts, NrIssuePorts) present decoded_entry_i[j] and decoded_valid_i[j] combinationally.
  - Bypassed lanes that are acked are counted in P and are not written to storage; the un-acked remainder is written.
  - Latency is 0 cycles when the buffer is empty.
- ID_ISSUE_BUF_BYPASS_EN undefined: outputs come from storage only, with a fixed 1-cycle latency.

## Structure
- issue_entry_t is a packed struct { scoreboard_entry_t sbe; logic [31:0] orig_instr; logic is_ctrl_flow; logic is_compressed }. It lives in ariane_pkg so the decoder and issue stage share it.
- Sub-module id_buf_prefix_cnt (parameter Width): counts the leading contiguous ones of a vector. It is instantiated twice, once for issue_ack_i to give P and once for decoded_valid_i & decoded_ready_o to give A.

## Test plan
- **Reset:** hold rst_i for 3 cycles with decoded_valid_i = 2'b11 -> decoded_ready_o = 0, issue_valid_o = 0, occupancy_o = 0. The cycle after reset, decoded_ready_o = 2'b11.
- **Basic fill and drain:** Depth=4, 2/2 lanes. Push pairs with orig_instr (0x11,0x22), then (0x33,0x44), with no ack -> occupancy_o = 4, decoded_ready_o = 0. Ack 2'b11 for 2 cycles -> outputs (0x11,0x22) then (0x33,0x44), in order.
- **Full with simultaneous pop and push:** cnt = 4, ack 2'b01 with valid 2'b11 -> decoded_ready_o = 2'b01, one entry accepted, occupancy_o stays 4.
- **Wrap-around:** advance pointers to wr = 3, then push 0xA0,0xB0 -> next-cycle issue order after earlier entries drain is 0xA0, 0xB0, with storage slots 3 and 0 written.
- **Flush:** with cnt = 3, assert flush_i together with valid 2'b11 and ack 2'b01 -> decoded_ready_o = 0 that cycle; next cycle occupancy_o = 0 and issue_valid_o = 0.
- **Bypass (ID_ISSUE_BUF_BYPASS_EN):** empty buffer, push 0x55,0x66, ack 2'b01 in the same cycle -> issue_entry_o[0].orig_instr = 0x55 in the same cycle; next cycle occupancy_o = 1 and issue lane 0 shows 0x66.

Source files
------------

// File: rtl/id_issue_buffer_pkg.sv
// Shared types for the decode-to-issue buffer: issue entry layout and a minimal core config.
package id_issue_buffer_pkg;

  typedef struct packed {
    int unsigned xlen;
  } cva6_cfg_t;

  localparam cva6_cfg_t Cva6CfgEmpty = '{xlen: 32};

  typedef enum logic [1:0] {FuNone, FuAlu, FuLsu, FuCtrl} fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        valid;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic [31:0]       orig_instr;
    logic              is_ctrl_flow;
    logic              is_compressed;
  } issue_entry_t;

endpackage

// File: rtl/id_buf_prefix_cnt.sv
// Counts the leading contiguous ones of a vector, starting at bit 0.
module id_buf_prefix_cnt #(
  parameter int unsigned Width = 2
) (
  input  logic [Width-1:0]             vec_i,
  output logic [$clog2(Width+1)-1:0]   cnt_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic run;

  always_comb begin
    cnt_o = '0;
    run   = 1'b1;
    for (int unsigned i = 0; i < Width; i++) begin
      run = run & vec_i[i];
      if (run) cnt_o = cnt_o + CntW'(1);
    end
  end

endmodule

// File: rtl/id_issue_buffer.sv
// Multi-lane circular decode-to-issue buffer with flush.
// Define ID_ISSUE_BUF_BYPASS_EN to forward decoder lanes straight to issue when empty.
module id_issue_buffer
  import id_issue_buffer_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg       = Cva6CfgEmpty,
  parameter int unsigned NrDecodePorts = 2,
  parameter int unsigned NrIssuePorts  = 2,
  parameter int unsigned Depth         = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  issue_entry_t [NrDecodePorts-1:0]      decoded_entry_i,
  input  logic         [NrDecodePorts-1:0]      decoded_valid_i,
  output logic         [NrDecodePorts-1:0]      decoded_ready_o,
  output issue_entry_t [NrIssuePorts-1:0]       issue_entry_o,
  output logic         [NrIssuePorts-1:0]       issue_valid_o,
  input  logic         [NrIssuePorts-1:0]       issue_ack_i,
  output logic         [$clog2(Depth+1)-1:0]    occupancy_o
);

  localparam int unsigned PtrW     = $clog2(Depth);
  localparam int unsigned CntW     = $clog2(Depth + 1);
  localparam int unsigned ACntW    = $clog2(NrDecodePorts + 1);
  localparam int unsigned PCntW    = $clog2(NrIssuePorts + 1);
  localparam int unsigned AW       = CntW + 2;
  localparam int unsigned NrBypass = (NrDecodePorts < NrIssuePorts) ? NrDecodePorts : NrIssuePorts;

  typedef logic [AW-1:0] arith_t;

  if (((Depth & (Depth - 1)) != 0) || (Depth < 2) || (Depth < NrDecodePorts) ||
      (Depth < NrIssuePorts)) begin : g_bad_depth
    $error("Depth must be a power of two >= 2 and >= both lane counts");
  end
  if (CVA6Cfg.xlen != 32) begin : g_bad_xlen
    $error("issue_entry_t is laid out for a 32-bit core");
  end

  issue_entry_t [Depth-1:0] storage_q, storage_d;
  logic [PtrW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [PCntW-1:0]         pop_cnt, skip;
  logic [ACntW-1:0]         push_cnt;
  arith_t                   free;
  logic                     bypass;
  logic [PtrW-1:0]          slot;

  id_buf_prefix_cnt #(.Width(NrIssuePorts)) u_pop_cnt (
    .vec_i (issue_ack_i),
    .cnt_o (pop_cnt)
  );

  id_buf_prefix_cnt #(.Width(NrDecodePorts)) u_push_cnt (
    .vec_i (decoded_valid_i & decoded_ready_o),
    .cnt_o (push_cnt)
  );

`ifdef ID_ISSUE_BUF_BYPASS_EN
  assign bypass = (cnt_q == '0) && !flush_i && !rst_i;
`else
  assign bypass = 1'b0;
`endif

  // Acked bypass lanes never touch storage or the read pointer.
  assign skip = bypass ? pop_cnt : '0;
  assign free = arith_t'(Depth) - arith_t'(cnt_q) + arith_t'(pop_cnt);
  assign occupancy_o = cnt_q;

  always_comb begin
    for (int k = 0; k < NrDecodePorts; k++) begin
      decoded_ready_o[k] = (free > arith_t'(k)) && !flush_i && !rst_i;
    end
  end

  always_comb begin
    for (int j = 0; j < NrIssuePorts; j++) begin
      issue_valid_o[j] = cnt_q > CntW'(j);
      issue_entry_o[j] = issue_valid_o[j] ? storage_q[rd_q + PtrW'(j)] : '0;
    end
`ifdef ID_ISSUE_BUF_BYPASS_EN
    if (bypass) begin
      for (int j = 0; j < NrBypass; j++) begin
        issue_valid_o[j] = decoded_valid_i[j];
        issue_entry_o[j] = decoded_valid_i[j] ? decoded_entry_i[j] : '0;
      end
    end
`endif
  end

  always_comb begin
    storage_d = storage_q;
    slot      = '0;
    for (int k = 0; k < NrDecodePorts; k++) begin
      if (k < int'(push_cnt) && k >= int'(skip)) begin
        slot            = wr_q + PtrW'(k) - PtrW'(skip);
        storage_d[slot] = decoded_entry_i[k];
      end
    end
    wr_d  = wr_q + PtrW'(push_cnt) - PtrW'(skip);
    rd_d  = rd_q + PtrW'(pop_cnt) - PtrW'(skip);
    cnt_d = CntW'(arith_t'(cnt_q) + arith_t'(push_cnt) - arith_t'(pop_cnt));
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      storage_q <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      storage_q <= storage_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
    end
  end

  ack_prefix_of_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (issue_ack_i & ~issue_valid_o) == '0);

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed, table-driven bench for id_issue_buffer (Depth 4, 2 decode / 2 issue lanes).
module tb_id_issue_buffer;
  import id_issue_buffer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, flush;
  issue_entry_t [1:0] dec_entry;
  logic [1:0]         dec_valid, dec_ready;
  issue_entry_t [1:0] iss_entry;
  logic [1:0]         iss_valid, ack;
  logic [2:0]         occ;

  id_issue_buffer #(
    .CVA6Cfg       (Cva6CfgEmpty),
    .NrDecodePorts (2),
    .NrIssuePorts  (2),
    .Depth         (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .decoded_entry_i (dec_entry),
    .decoded_valid_i (dec_valid),
    .decoded_ready_o (dec_ready),
    .issue_entry_o   (iss_entry),
    .issue_valid_o   (iss_valid),
    .issue_ack_i     (ack),
    .occupancy_o     (occ)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [1:0]  vld;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  ack;
    logic [1:0]  rdy;
    logic [1:0]  ivld;
    logic [31:0] o0;
    logic [31:0] o1;
    logic [2:0]  occ;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Every field depends on x so a zero tag yields the all-zero entry.
  function automatic issue_entry_t mk(input logic [31:0] x);
    issue_entry_t e;
    e.sbe.pc         = x << 2;
    e.sbe.fu         = fu_t'(x[1:0]);
    e.sbe.op         = x[6:0];
    e.sbe.rs1        = x[4:0];
    e.sbe.rs2        = x[8:4];
    e.sbe.rd         = x[7:3];
    e.sbe.result     = {x[15:0], x[31:16]};
    e.sbe.valid      = |x;
    e.orig_instr     = x;
    e.is_ctrl_flow   = x[1];
    e.is_compressed  = x[0];
    return e;
  endfunction

  task automatic add(input logic r, input logic f, input logic [1:0] vld,
                     input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] a,
                     input logic [1:0] rdy, input logic [1:0] ivld,
                     input logic [31:0] o0, input logic [31:0] o1, input logic [2:0] oc);
    vec_t v;
    v.rst = r; v.flush = f; v.vld = vld; v.i0 = i0; v.i1 = i1; v.ack = a;
    v.rdy = rdy; v.ivld = ivld; v.o0 = o0; v.o1 = o1; v.occ = oc;
    vecs.push_back(v);
  endtask

  task automatic chk_bits(input string name, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk_ent(input string name, input issue_entry_t got, input issue_entry_t exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got instr %h (%h), expected instr %h (%h)",
               name, got.orig_instr, got, exp.orig_instr, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [1:0] vld,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] a);
    rst          = r;
    flush        = f;
    dec_valid    = vld;
    dec_entry[0] = mk(i0);
    dec_entry[1] = mk(i1);
    ack          = a;
  endtask

  task automatic check_all(input string tag, input logic [1:0] rdy, input logic [1:0] ivld,
                           input logic [31:0] o0, input logic [31:0] o1, input logic [2:0] oc);
    n_vec++;
    chk_bits({tag, " ready"}, 32'(dec_ready), 32'(rdy));
    chk_bits({tag, " issue_valid"}, 32'(iss_valid), 32'(ivld));
    chk_ent({tag, " issue_entry0"}, iss_entry[0], mk(o0));
    chk_ent({tag, " issue_entry1"}, iss_entry[1], mk(o1));
    chk_bits({tag, " occupancy"}, 32'(occ), 32'(oc));
  endtask

  initial begin
    vec_t v;
    //   rst   flush vld    i0      i1      ack  | rdy   ivld   o0      o1      occ
    // Reset held with valid lanes asserted
    add(1'b1, 1'b0, 2'b11, 32'h11, 32'h22, 2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 3'd0);
    add(1'b1, 1'b0, 2'b11, 32'h11, 32'h22, 2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 3'd0);
    add(1'b1, 1'b0, 2'b11, 32'h11, 32'h22, 2'b00, 2'b00, 2'b00, 32'h00, 32'h00, 3'd0);
    // Fill and drain
    add(1'b0, 1'b0, 2'b11, 32'h11, 32'h22, 2'b00, 2'b11, 2'b00, 32'h00, 32'h00, 3'd0);
    add(1'b0, 1'b0, 2'b11, 32'h33, 32'h44, 2'b00, 2'b11, 2'b11, 32'h11, 32'h22, 3'd2);
    add(1'b0, 1'b0, 2'b11, 32'h55, 32'h66, 2'b00, 2'b00, 2'b11, 32'h11, 32'h22, 3'd4);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b11, 2'b11, 2'b11, 32'h11, 32'h22, 3'd4);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b11, 2'b11, 2'b11, 32'h33, 32'h44, 3'd2);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b00, 2'b11, 2'b00, 32'h00, 32'h00, 3'd0);
    // Full buffer, pop one and push one in the same cycle
    add(1'b0, 1'b0, 2'b11, 32'hA1, 32'hA2, 2'b00, 2'b11, 2'b00, 32'h00, 32'h00, 3'd0);
    add(1'b0, 1'b0, 2'b11, 32'hA3, 32'hA4, 2'b00, 2'b11, 2'b11, 32'hA1, 32'hA2, 3'd2);
    add(1'b0, 1'b0, 2'b11, 32'hA5, 32'hA6, 2'b01, 2'b01, 2'b11, 32'hA1, 32'hA2, 3'd4);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b00, 2'b00, 2'b11, 32'hA2, 32'hA3, 3'd4);
    // Drain, then step wr to 3 and push across the wrap
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b11, 2'b11, 2'b11, 32'hA2, 32'hA3, 3'd4);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b11, 2'b11, 2'b11, 32'hA4, 32'hA5, 3'd2);
    add(1'b0, 1'b0, 2'b01, 32'hB1, 32'h77, 2'b00, 2'b11, 2'b00, 32'h00, 32'h00, 3'd0);
    add(1'b0, 1'b0, 2'b01, 32'hB2, 32'h77, 2'b01, 2'b11, 2'b01, 32'hB1, 32'h00, 3'd1);
    add(1'b0, 1'b0, 2'b11, 32'hA0, 32'hB0, 2'b01, 2'b11, 2'b01, 32'hB2, 32'h00, 3'd1);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b00, 2'b11, 2'b11, 32'hA0, 32'hB0, 3'd2);
    // Lane 1 valid behind an invalid lane 0 is ignored
    add(1'b0, 1'b0, 2'b10, 32'hC1, 32'hC2, 2'b00, 2'b11, 2'b11, 32'hA0, 32'hB0, 3'd2);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b00, 2'b11, 2'b11, 32'hA0, 32'hB0, 3'd2);
    // Flush at occupancy 3 with push and pop requested
    add(1'b0, 1'b0, 2'b01, 32'hC3, 32'h00, 2'b00, 2'b11, 2'b11, 32'hA0, 32'hB0, 3'd2);
    add(1'b0, 1'b1, 2'b11, 32'hD1, 32'hD2, 2'b01, 2'b00, 2'b11, 32'hA0, 32'hB0, 3'd3);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b00, 2'b11, 2'b00, 32'h00, 32'h00, 3'd0);
    add(1'b0, 1'b0, 2'b11, 32'hE1, 32'hE2, 2'b00, 2'b11, 2'b00, 32'h00, 32'h00, 3'd0);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b01, 2'b11, 2'b11, 32'hE1, 32'hE2, 3'd2);
    add(1'b0, 1'b0, 2'b00, 32'h00, 32'h00, 2'b00, 2'b11, 2'b01, 32'hE2, 32'h00, 3'd1);

    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    @(posedge clk);

    foreach (vecs[i]) begin
      v = vecs[i];
`ifdef ID_ISSUE_BUF_BYPASS_EN
      // Empty buffer: decoder lanes appear directly on the issue lanes.
      if (v.occ == 3'd0 && !v.rst && !v.flush) begin
        v.ivld = v.vld;
        v.o0   = v.vld[0] ? v.i0 : 32'h0;
        v.o1   = v.vld[1] ? v.i1 : 32'h0;
      end
`endif
      #1;
      drive(v.rst, v.flush, v.vld, v.i0, v.i1, v.ack);
      #3;
      check_all($sformatf("vec%0d", i), v.rdy, v.ivld, v.o0, v.o1, v.occ);
      @(posedge clk);
    end

    // Reset while occupied: ready drops at once, contents vanish after the edge.
    #1;
    drive(1'b1, 1'b0, 2'b11, 32'hF1, 32'hF2, 2'b00);
    #3;
    check_all("midrst_during", 2'b00, 2'b01, 32'hE2, 32'h00, 3'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    #3;
    check_all("midrst_after", 2'b11, 2'b00, 32'h00, 32'h00, 3'd0);
    @(posedge clk);

`ifdef ID_ISSUE_BUF_BYPASS_EN
    // Same-cycle bypass: lane 0 acked directly, lane 1 stored.
    #1;
    drive(1'b0, 1'b0, 2'b11, 32'h55, 32'h66, 2'b01);
    #3;
    check_all("bypass_same", 2'b11, 2'b11, 32'h55, 32'h66, 3'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    #3;
    check_all("bypass_next", 2'b11, 2'b01, 32'h66, 32'h00, 3'd1);
    @(posedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
